// File: rtl/mem_access_unit.sv
// Unified instruction/data memory stage for a multi-cycle MIPS32 core.
// Word access to an internal single-port RAM with programmable wait states.
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              iord,
    input  logic              ir_write,
    input  logic              mdr_write,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic [5:0]        op,
    output logic [5:0]        func,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [IDX_W-1:0]   idx_r;
    logic [DATA_W-1:0]  wdata_r;
    logic               is_write_r;
    logic               ir_wr_r;
    logic               mdr_wr_r;

    logic [DATA_W-1:0]  ram [DEPTH];

    logic               req_s;
    logic [DATA_W-1:0]  addr_s;
    logic [DATA_W-1:0]  word_s;
    logic               err_s;

    assign req_s  = mem_read | mem_write;
    assign addr_s = iord ? alu_out : pc;
    assign word_s = addr_s >> 2;
    // Misaligned, beyond the RAM, or an ambiguous read+write request.
    assign err_s  = (addr_s[1:0] != 2'b00) || (word_s >= DATA_W'(DEPTH)) ||
                    (mem_read && mem_write);

    assign op   = ir[31:26];
    assign func = ir[5:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s && !err_s) begin
                    if (WAIT_CYCLES > 0) begin
                        state_next_s = ST_WAIT;
                    end else begin
                        state_next_s = ST_ACCESS;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_W'(0)) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ACCESS: state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // Request latching, wait counter, handshake and IR/MDR loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_W'(0);
            ir       <= DATA_W'(0);
            mdr      <= DATA_W'(0);
            busy     <= 1'b0;
            done     <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_s && err_s) begin
                        done     <= 1'b1;
                        addr_err <= 1'b1;
                    end else if (req_s) begin
                        idx_r      <= word_s[IDX_W-1:0];
                        wdata_r    <= wdata;
                        is_write_r <= mem_write;
                        ir_wr_r    <= ir_write;
                        mdr_wr_r   <= mdr_write;
                        busy       <= 1'b1;
                        cnt_r      <= CNT_W'(CNT_INIT);
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != CNT_W'(0)) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!is_write_r && ir_wr_r) begin
                        ir <= ram[idx_r];
                    end
                    if (!is_write_r && mdr_wr_r) begin
                        mdr <= ram[idx_r];
                    end
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

    // RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && state_r == ST_ACCESS && is_write_r) begin
            ram[idx_r] <= wdata_r;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with WAIT_CYCLES=2 and
// a second instance with WAIT_CYCLES=0 for back-to-back accesses.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mem_read, mem_write, iord, ir_write, mdr_write;
    logic [31:0] pc, alu_out, wdata, ir, mdr;
    logic [5:0]  op, func;
    logic        busy, done, addr_err;

    logic        rst_z, mem_read_z, mem_write_z, iord_z, ir_write_z, mdr_write_z;
    logic [31:0] pc_z, alu_out_z, wdata_z, ir_z, mdr_z;
    logic [5:0]  op_z, func_z;
    logic        busy_z, done_z, addr_err_z;

    int n_pass  = 0;
    int n_total = 0;

    mem_access_unit #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .mdr_write(mdr_write), .pc(pc),
        .alu_out(alu_out), .wdata(wdata), .ir(ir), .mdr(mdr), .op(op),
        .func(func), .busy(busy), .done(done), .addr_err(addr_err)
    );

    mem_access_unit #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst_z), .mem_read(mem_read_z), .mem_write(mem_write_z),
        .iord(iord_z), .ir_write(ir_write_z), .mdr_write(mdr_write_z), .pc(pc_z),
        .alu_out(alu_out_z), .wdata(wdata_z), .ir(ir_z), .mdr(mdr_z), .op(op_z),
        .func(func_z), .busy(busy_z), .done(done_z), .addr_err(addr_err_z)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One request on the WAIT_CYCLES=2 instance; returns cycles to done and busy cycles.
    task automatic access(input logic rd, input logic wr, input logic io, input logic irw,
                          input logic mdrw, input logic [31:0] pcv, input logic [31:0] alv,
                          input logic [31:0] wd, output int lat, output int busy_n);
        mem_read = rd; mem_write = wr; iord = io; ir_write = irw; mdr_write = mdrw;
        pc = pcv; alu_out = alv; wdata = wd;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        lat = 0; busy_n = 0;
        while (!done && lat < 20) begin
            if (busy) busy_n++;
            tick();
            lat++;
        end
    endtask

    // Rejected request: error pulse next cycle, never busy.
    task automatic err_req(input string tag, input logic rd, input logic wr, input logic [31:0] alv);
        mem_read = rd; mem_write = wr; iord = 1'b1; mdr_write = 1'b1; ir_write = 1'b0;
        alu_out = alv; wdata = 32'h0BAD_0BAD;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_err"}, 32'(addr_err), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        tick();
        chk({tag, "_done_clr"}, 32'(done), 32'd0);
        chk({tag, "_err_clr"}, 32'(addr_err), 32'd0);
        chk({tag, "_mdr"}, mdr, 32'hDEAD_BEEF);
    endtask

    // One request on the WAIT_CYCLES=0 instance; calls chain with no gap.
    task automatic acc0(input string tag, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wd);
        mem_read_z = rd; mem_write_z = ~rd; iord_z = ~rd; ir_write_z = rd;
        pc_z = addr; alu_out_z = addr; wdata_z = wd;
        tick();
        mem_read_z = 1'b0; mem_write_z = 1'b0;
        chk({tag, "_busy"}, 32'(busy_z), 32'd1);
        chk({tag, "_nodone"}, 32'(done_z), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(done_z), 32'd1);
        chk({tag, "_idle"}, 32'(busy_z), 32'd0);
    endtask

    initial begin
        int lat, bn, dones;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; iord = 1'b0;
        ir_write = 1'b0; mdr_write = 1'b0; pc = 32'd0; alu_out = 32'd0; wdata = 32'd0;
        rst_z = 1'b1; mem_read_z = 1'b0; mem_write_z = 1'b0; iord_z = 1'b0;
        ir_write_z = 1'b0; mdr_write_z = 1'b0; pc_z = 32'd0; alu_out_z = 32'd0; wdata_z = 32'd0;
        tick(); tick();
        rst = 1'b0; rst_z = 1'b0;
        chk("rst_ir", ir, 32'd0);
        chk("rst_mdr", mdr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);

        // Seed 0x10, read it into both registers, then abandon a write by reset.
        access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h10, 32'h1111_1111, lat, bn);
        chk("seed_lat", 32'(lat), 32'd3);
        access(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'h10, 32'd0, lat, bn);
        chk("seed_ir", ir, 32'h1111_1111);
        chk("seed_mdr", mdr, 32'h1111_1111);
        mem_write = 1'b1; iord = 1'b1; alu_out = 32'h10; wdata = 32'h2222_2222;
        tick();
        mem_write = 1'b0;
        tick();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("midrst_ir", ir, 32'd0);
        chk("midrst_mdr", mdr, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h10, 32'd0, lat, bn);
        chk("midrst_ram", mdr, 32'h1111_1111);

        // Write then read back through MDR.
        access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h40, 32'hDEAD_BEEF, lat, bn);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_busy_cycles", 32'(bn), 32'd3);
        chk("wr_err", 32'(addr_err), 32'd0);
        access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h40, 32'd0, lat, bn);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_mdr", mdr, 32'hDEAD_BEEF);
        chk("rd_ir_hold", ir, 32'd0);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);

        // Instruction fetch from pc.
        access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h4, 32'h012A_4020, lat, bn);
        access(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4, 32'h40, 32'd0, lat, bn);
        chk("fetch_ir", ir, 32'h012A_4020);
        chk("fetch_op", 32'(op), 32'h00);
        chk("fetch_func", 32'(func), 32'h20);
        chk("fetch_mdr_hold", mdr, 32'hDEAD_BEEF);

        // Highest valid word, then rejected requests.
        access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h3FC, 32'hA5A5_A5A5, lat, bn);
        chk("top_lat", 32'(lat), 32'd3);
        chk("top_err", 32'(addr_err), 32'd0);
        err_req("misalign", 1'b1, 1'b0, 32'h42);
        err_req("range", 1'b1, 1'b0, 32'h400);
        err_req("conflict", 1'b1, 1'b1, 32'h40);

        // A write raised during WAIT of a read must be ignored.
        access(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'h8, 32'h5555_5555, lat, bn);
        mem_read = 1'b1; iord = 1'b1; mdr_write = 1'b1; alu_out = 32'h8;
        tick();
        mem_read = 1'b0;
        tick();
        mem_write = 1'b1; wdata = 32'h9999_9999;
        tick();
        mem_write = 1'b0;
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dones++;
        end
        chk("busy_one_done", 32'(dones), 32'd1);
        chk("busy_rd_mdr", mdr, 32'h5555_5555);
        access(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'h8, 32'd0, lat, bn);
        chk("busy_ram_kept", mdr, 32'h5555_5555);

        // Zero wait states, requests issued in each done cycle.
        acc0("z_w0", 1'b0, 32'h0, 32'hAAAA_0000);
        acc0("z_w1", 1'b0, 32'h4, 32'hBBBB_0001);
        acc0("z_r0", 1'b1, 32'h0, 32'd0);
        chk("z_ir0", ir_z, 32'hAAAA_0000);
        acc0("z_r1", 1'b1, 32'h4, 32'd0);
        chk("z_ir1", ir_z, 32'hBBBB_0001);
        chk("z_op1", 32'(op_z), 32'h2E);
        chk("z_func1", 32'(func_z), 32'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Unified instruction/data memory stage of the multi-cycle MIPS32 core. It sits directly downstream of the control FSM and consumes that FSM's MemRead, MemWrite, IorD, IR and MDR strobes.
- Selects the address: PC for fetch, ALU result register for load/store.
- Performs a word access to an internal single-port RAM with a programmable number of wait states.
- Loads the Instruction Register or Memory Data Register.
- Returns op/func fields and a busy/done handshake to control.

Parameters:
DATA_W, 32, data and address width in bits
DEPTH, 256, RAM size in 32-bit words; valid byte addresses 0 .. 4*DEPTH-1
WAIT_CYCLES, 2, wait states inserted before each access (0 allowed)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
mem_read  in  1  read request (control MemRead)
mem_write  in  1  write request (control MemWrite)
iord  in  1  address select: 0 = pc, 1 = alu_out
ir_write  in  1  on read, load ir
mdr_write  in  1  on read, load mdr
pc  in  DATA_W  program counter byte address
alu_out  in  DATA_W  ALU result register byte address
wdata  in  DATA_W  store data (register B)
ir  out  DATA_W  instruction register
mdr  out  DATA_W  memory data register
op  out  6  ir[31:26], combinational from ir
func  out  6  ir[5:0], combinational from ir
busy  out  1  access in progress; requests ignored
done  out  1  one-cycle pulse, access (or rejected access) finished
addr_err  out  1  one-cycle pulse with done: misaligned, out-of-range or conflicting request

Behaviour:
- Reset values (rst high at a rising edge): state IDLE, wait counter 0, ir 0, mdr 0, busy 0, done 0, addr_err 0.
- RAM contents are not reset.
- Reset overrides everything, including mid-access: the access is abandoned, no RAM write, ir/mdr forced to 0.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - Requests are sampled only in IDLE.
  - On mem_read or mem_write high, latch: addr = iord ? alu_out : pc, wdata, request type, ir_write, mdr_write.
  - Error check: addr[1:0] != 0, or word index addr>>2 >= DEPTH, or mem_read and mem_write both high. On error: no access, no register update; next cycle done=1, addr_err=1, state stays IDLE.
  - Otherwise busy=1 next cycle. State goes to WAIT if WAIT_CYCLES>0, else ACCESS.
- WAIT:
  - Counter loads WAIT_CYCLES-1 on entry.
  - Decrement each cycle; move to ACCESS when the counter is 0 (exactly WAIT_CYCLES cycles in WAIT).
- ACCESS (one cycle): on the exit edge, perform the access and go to IDLE with busy=0, done=1.
  - Write: ram[idx] <= latched wdata.
  - Read: ir <= ram[idx] if latched ir_write; mdr <= ram[idx] if latched mdr_write; both may load; neither = read discarded.
- Latency: request sampled at edge E0 -> done high in the cycle after edge E0+WAIT_CYCLES+1. New ir/mdr data is visible in the same cycle as done.
- done and addr_err are high for exactly one cycle.
- Back-to-back: a request present during the done cycle (state IDLE) is accepted, so there is no dead cycle.
- Requests while busy are ignored entirely; address or data changes while busy have no effect.
- ir and mdr hold their value between loads. op and func always track ir.

Test Plan:
- Reset: assert rst 2 cycles mid-WAIT of a pending write to 0x10 -> ir=0, mdr=0, busy=0, done=0; a later read of 0x10 shows the word unchanged.
- Write then read, WAIT_CYCLES=2:
  - mem_write, iord=1, alu_out=0x40, wdata=0xDEADBEEF -> busy 3 cycles, done pulse 3 cycles after the request edge.
  - Then mem_read, iord=1, mdr_write=1 -> mdr=0xDEADBEEF with done; ir unchanged.
- Fetch: preload ram[1]=0x012A4020 (add $t0,$t1,$t2); mem_read, iord=0, pc=0x4, ir_write=1 -> ir=0x012A4020, op=0x00, func=0x20.
- Errors:
  - alu_out=0x42 read -> done=1 and addr_err=1 on the next cycle, mdr unchanged, busy never set.
  - alu_out=0x400 with DEPTH=256 -> same response.
  - mem_read and mem_write both high -> same response.
- Busy rejection: second mem_write to 0x8 raised during WAIT of a read -> ignored; ram[2] unchanged, only one done pulse.
- WAIT_CYCLES=0 back-to-back: reads of pc=0x0 then 0x4 issued on consecutive done cycles -> each done comes 1 cycle after its request edge, and ir takes the two words in order.
